// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream decrypter and the key-search controller.
// State encodings are fixed so the debug state output decodes the same way everywhere.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ISSUE_I = 4'd1,
        WAIT_I  = 4'd2,
        CAP_I   = 4'd3,
        WAIT_J  = 4'd4,
        CAP_J   = 4'd5,
        WR_I    = 4'd6,
        ISSUE_F = 4'd7,
        WAIT_F  = 4'd8,
        CAP_F   = 4'd9,
        WRITE   = 4'd10,
        DONE    = 4'd11
    } state_t;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Plaintext character filter: lowercase letters and space are the only accepted bytes.
// Purely combinational so the key-search controller can reuse it on its own datapath.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       valid
);

    assign valid = ((data >= CHAR_LO) && (data <= CHAR_HI)) || (data == CHAR_SP);

endmodule

// File: rtl/rc4_decrypt_checked.sv
// RC4 PRGA over a pre-shuffled scratchpad, XORing the keystream with the message ROM
// and writing plaintext to the result RAM, with optional early abort on non-text bytes.
module rc4_decrypt_checked
    import rc4_pkg::*;
#(
    parameter int S_ADDR_WIDTH   = 8,
    parameter int MSG_ADDR_WIDTH = 5,
    parameter int MEM_LAT        = 2,
    parameter int CHECK_EN       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MSG_ADDR_WIDTH:0]   msg_len,
    output logic                      busy,
    output logic                      finish,
    output logic                      success,
    output logic [MSG_ADDR_WIDTH-1:0] fail_idx,
    output logic [S_ADDR_WIDTH-1:0]   s_addr,
    output logic [7:0]                s_data,
    output logic                      s_wren,
    input  logic [7:0]                s_q,
    output logic [MSG_ADDR_WIDTH-1:0] msg_addr,
    input  logic [7:0]                msg_q,
    output logic [MSG_ADDR_WIDTH-1:0] result_addr,
    output logic [7:0]                result_data,
    output logic                      result_wren,
    output logic [3:0]                dbg_state
);

    // Handshake: start is sampled only in IDLE; busy rises the cycle after an accepted
    // start and drops together with the single-cycle finish pulse; success/fail_idx hold
    // from finish until the next accepted start.
    localparam logic [MSG_ADDR_WIDTH:0]   MAX_LEN   = {1'b1, {MSG_ADDR_WIDTH{1'b0}}};
    localparam logic [S_ADDR_WIDTH-1:0]   S_ONE     = S_ADDR_WIDTH'(1);
    localparam logic [MSG_ADDR_WIDTH-1:0] K_ONE     = MSG_ADDR_WIDTH'(1);
    localparam logic [1:0]                WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;
    localparam bit                        HAS_WAIT  = (MEM_LAT > 1);

    state_t                      state;
    logic [S_ADDR_WIDTH-1:0]     i, j;
    logic [MSG_ADDR_WIDTH-1:0]   k, last_k;
    logic [7:0]                  si, sj, p;
    logic [1:0]                  wait_cnt;
    logic [MSG_ADDR_WIDTH:0]     len_c;
    logic [7:0]                  ks_byte;
    logic                        char_ok;

    always_comb begin
        len_c   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
        ks_byte = s_q ^ msg_q;
    end

    rc4_char_check u_char_check (
        .data  (ks_byte),
        .valid (char_ok)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            last_k      <= '0;
            si          <= '0;
            sj          <= '0;
            p           <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            success     <= 1'b0;
            fail_idx    <= '0;
            s_addr      <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            msg_addr    <= '0;
            result_addr <= '0;
            result_data <= '0;
            result_wren <= 1'b0;
        end else begin
            s_wren      <= 1'b0;
            result_wren <= 1'b0;
            finish      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        fail_idx <= '0;
                        last_k   <= MSG_ADDR_WIDTH'(len_c - 1'b1);
                        busy     <= 1'b1;
                        success  <= (len_c == '0);
                        state    <= (len_c == '0) ? DONE : ISSUE_I;
                    end
                end
                ISSUE_I: begin
                    i        <= i + S_ONE;
                    s_addr   <= i + S_ONE;
                    wait_cnt <= WAIT_INIT;
                    state    <= HAS_WAIT ? WAIT_I : CAP_I;
                end
                WAIT_I: begin
                    if (wait_cnt == 2'd0) state <= CAP_I;
                    else wait_cnt <= wait_cnt - 2'd1;
                end
                CAP_I: begin
                    si       <= s_q;
                    j        <= j + S_ADDR_WIDTH'(s_q);
                    s_addr   <= j + S_ADDR_WIDTH'(s_q);
                    wait_cnt <= WAIT_INIT;
                    state    <= HAS_WAIT ? WAIT_J : CAP_J;
                end
                WAIT_J: begin
                    if (wait_cnt == 2'd0) state <= CAP_J;
                    else wait_cnt <= wait_cnt - 2'd1;
                end
                // s_addr still holds j here, so the swap's first half is just data + enable.
                CAP_J: begin
                    sj     <= s_q;
                    s_data <= si;
                    s_wren <= 1'b1;
                    state  <= WR_I;
                end
                WR_I: begin
                    s_addr <= i;
                    s_data <= sj;
                    s_wren <= 1'b1;
                    state  <= ISSUE_F;
                end
                ISSUE_F: begin
                    s_addr   <= S_ADDR_WIDTH'(si + sj);
                    msg_addr <= k;
                    wait_cnt <= WAIT_INIT;
                    state    <= HAS_WAIT ? WAIT_F : CAP_F;
                end
                WAIT_F: begin
                    if (wait_cnt == 2'd0) state <= CAP_F;
                    else wait_cnt <= wait_cnt - 2'd1;
                end
                CAP_F: begin
                    p <= ks_byte;
                    if ((CHECK_EN != 0) && !char_ok) begin
                        fail_idx <= k;
                        success  <= 1'b0;
                        state    <= DONE;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    result_addr <= k;
                    result_data <= p;
                    result_wren <= 1'b1;
                    if (k == last_k) begin
                        success <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k     <= k + K_ONE;
                        state <= ISSUE_I;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
